// File: rtl/bcd_conv_ctrl.sv
// bcd_conv_ctrl: handshaked binary-to-BCD converter (shift-and-add-3).
// One operand bit is consumed per SHIFT cycle, so a conversion takes BIN_W
// cycles. The result is held in DONE until the consumer takes it.
// Optional build macro: BCD_CONV_CTRL_BLANK_EN enables the leading-zero
// blank mask; without it, blank is tied to zero.

// Per-digit correction: a digit of 5 or more is bumped by 3 so that the
// following left shift carries into the next decade.
module bcd_conv_ctrl_dig (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bcd_conv_ctrl #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         state;
  logic [BIN_W-1:0]   opnd;
  logic [BW-1:0]      bcd_r;
  logic [CW-1:0]      cnt;

  logic [BW-1:0]       bcd_adj;
  logic [BW+BIN_W-1:0] shf;
  logic [BW-1:0]       bcd_nxt;
  logic [BIN_W-1:0]    opnd_nxt;
  logic                last_shift;

  // Digit correctors, one per decade
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_conv_ctrl_dig u_dig (
        .d (bcd_r[4*g +: 4]),
        .q (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  // The operand MSB shifts into BCD bit 0; the top BCD bit falls off, which
  // cannot lose information while 10^DIGITS > 2^BIN_W - 1.
  assign shf        = {bcd_adj, opnd} << 1;
  assign bcd_nxt    = shf[BW+BIN_W-1:BIN_W];
  assign opnd_nxt   = shf[BIN_W-1:0];
  assign last_shift = (state == S_SHIFT) && (cnt == CW'(1));

  // Controller state, working registers and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      opnd  <= '0;
      bcd_r <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opnd  <= bin;
            bcd_r <= '0;
            cnt   <= CW'(BIN_W);
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_r <= bcd_nxt;
          opnd  <= opnd_nxt;
          cnt   <= cnt - CW'(1);
          if (last_shift) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake/status decode; in_ready is masked while reset is asserted
  assign in_ready  = (state == S_IDLE) && !rst;
  assign busy      = (state == S_SHIFT);
  assign out_valid = (state == S_DONE);
  assign bcd       = bcd_r;

`ifdef BCD_CONV_CTRL_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic [DIGITS-1:0] blank_r;
  logic              zero_above;

  // Digit k blanks when it and every higher digit of the final result are
  // zero; digit 0 is always shown so a zero result still displays "0".
  always_comb begin
    blank_nxt  = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above && (bcd_nxt[4*k +: 4] == 4'd0);
      blank_nxt[k] = zero_above;
    end
  end

  // Latch the mask on the edge that enters DONE so it is held with bcd
  always_ff @(posedge clk) begin
    if (rst)             blank_r <= '0;
    else if (last_shift) blank_r <= blank_nxt;
  end

  assign blank = blank_r;
`else
  assign blank = '0;
`endif

endmodule
